uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receive stage: over-samples the serial input `rxd` against an internal bit-period counter and de-serialises one character (start, data LSB first, optional parity, stop).
- Presents each character on a one-entry valid/ready output buffer.
- Sits between the board RX pin and the bus-side UART register/FIFO logic.
- Single clock domain; `rxd` is asynchronous and is synchronised internally.

Parameters:
- CLOCK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115_200: line rate. Derived constant CLKS_PER_BIT = CLOCK_FREQ/BAUD, which is 434 at the defaults.
- DATA_BITS, 8: data bits per character. Legal range 5..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting low resets all state immediately; de-assertion is synchronous to clk.
- rxd  in  1  serial line, idle high, asynchronous to clk.
- rx_data  out  DATA_BITS  received character. Valid while rx_valid=1.
- rx_valid  out  1  output buffer holds an unconsumed character.
- rx_ready  in  1  consumer accepts. Transfer happens on a clk edge with rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 when the optional feature is absent.
- overrun  out  1  one-cycle pulse: completed character dropped because the buffer was full.
- busy  out  1  receiver FSM not in IDLE.

Behaviour:
- Reset values:
  - rx_data=0; rx_valid, frame_err, parity_err, overrun and busy all 0.
  - FSM=IDLE; both synchroniser flops=1.
- Synchroniser: 2-flop on rxd. Added latency is 2 cycles; all decisions use the synchronised value rxs.
- Bit counter: clk_cnt counts 0..CLKS_PER_BIT-1, then wraps to 0. It is cleared on entry to START.
  - mid = (clk_cnt == CLKS_PER_BIT/2), i.e. 217 at defaults.
  - bend = (clk_cnt == CLKS_PER_BIT-1).
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: a falling edge of rxs (previous 1, current 0) moves to START. A line held low does not retrigger.
  - START:
    - At mid, rxs=1 means a glitch: return to IDLE with no output.
    - At bend, go to DATA with bit_idx=0.
  - DATA:
    - At mid, shift rxs into the shift register at the MSB end, right-shifting.
    - At bend, if bit_idx==DATA_BITS-1 go to PARITY (feature on) or STOP; otherwise increment bit_idx.
  - PARITY: at mid, capture the parity bit. At bend, go to STOP.
  - STOP: at mid, sample rxs and return to IDLE in the same cycle. Returning at mid lets the next start edge be caught early.
    - rxs=0: frame_err pulse; character discarded.
    - Parity mismatch: parity_err pulse; character discarded. If both errors occur, both pulse.
    - Otherwise the character is delivered to the buffer.
- Output buffer, on a delivery cycle:
  - rx_valid=0, or rx_valid & rx_ready: load rx_data, rx_valid=1, no overrun.
  - rx_valid=1 & !rx_ready: the new character is dropped, the old one is kept, overrun pulses.
  - With no delivery, rx_valid & rx_ready clears rx_valid. rx_data holds its last value.
- Latency: delivery occurs 2 + CLKS_PER_BIT*(1+DATA_BITS[+1]) + CLKS_PER_BIT/2 cycles after the falling edge of rxd.
- Error pulses never coincide with rx_valid rising for the same character.
- Reset mid-frame: everything returns to reset values immediately. After release, a low line is not treated as a start until it has returned high and fallen again.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds the PARITY state and one parity bit after the data bits.
  - Even parity: XOR of data bits and parity bit must be 0; a mismatch gives a parity_err pulse.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - parity_err is tied to 0 and the frame is one bit shorter.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - the CLOCK_FREQ default;
  - the function clks_per_bit(freq, baud).
- Sub-module uart_rx_sync: the 2-flop synchroniser plus falling-edge detector. Outputs rxs and fall; both flops reset to 1.
- The bit counter and FSM stay in uart_rx.

Test Plan:
1. 0x55, 8N1, defaults, rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0x55, 2+9*434+217 = 4125 cycles after the falling edge; all error outputs stay 0.
2. rxd low for 100 cycles then high → no rx_valid; busy returns to 0 at the START mid sample, ~219 cycles after the edge.
3. 0xA3 with stop bit forced 0 → frame_err 1-cycle pulse; rx_valid stays 0; the next 0x3C frame is received correctly.
4. Two frames 0x11, 0x22 with rx_ready=0 → rx_data=0x11 stays valid; overrun pulses at the second stop mid. Then rx_ready=1 → rx_valid clears.
5. Back-to-back 0x01,0x02,0x03 with rx_ready asserted on the delivery cycle → three values in order, no overrun.
6. rst low during DATA of a frame → outputs zero immediately. Release with rxd still low → no start until rxd goes high then low; then 0x7E is received. With UART_RX_PARITY_EN: 0x7E with parity bit 1 → parity_err pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int unsigned CLOCK_FREQ_DEFAULT = 50_000_000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd pin plus falling-edge detector on the
// synchronised line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic fall
);
    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       prev_q, prev_d;
    logic [1:0] warm_q, warm_d;

    always_comb begin
        meta_d = rxd;
        sync_d = meta_q;
        warm_d = {warm_q[0], 1'b1};
        // prev stays 0 until sync_q holds a real line sample, so a line already low
        // at reset release is never mistaken for a start edge.
        prev_d = warm_q[1] & sync_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b0;
            warm_q <= 2'b00;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

    assign rxs  = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of the synchronised line, one-entry valid/ready buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = CLOCK_FREQ_DEFAULT,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned CPB   = clks_per_bit(CLOCK_FREQ, BAUD);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2);
    localparam logic [CNT_W-1:0] CNT_BEND = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic                 rxs;
    logic                 fall;
    logic                 mid;
    logic                 bend;
    logic                 parity_bad;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .rxs  (rxs),
        .fall (fall)
    );

    assign mid  = (cnt_q == CNT_MID);
    assign bend = (cnt_q == CNT_BEND);

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits together with the parity bit must XOR to 0.
    assign parity_bad = ^{shift_q, par_q};
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = bend ? '0 : cnt_q + CNT_W'(1);
        end

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (mid && rxs) begin
                    state_d = IDLE;
                end else if (bend) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (mid) begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                end
                if (bend) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = AFTER_DATA;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid) begin
                    par_d = rxs;
                end
                if (bend) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (mid) begin
                    state_d = IDLE;
                    ferr_d  = ~rxs;
                    perr_d  = parity_bad;
                    if (rxs && !parity_bad) begin
                        if (valid_q && !rx_ready) begin
                            ovr_d = 1'b1;
                        end else begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule
